mtimer_responder: RTL and testbench

- Memory-mapped machine-timer peripheral; responder on the data-memory side of memory_controller, sharing the single_port_ram port contract (chip_select, output_enable, write_enable, byte_enable, busy).
- Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a control register.
- Raises a level timer interrupt for the core.
- Busy handshake is shaped like the RAM/ROM so the control unit's wait-on-busy sequencing is unchanged.

---
 rtl/mtimer_pkg.sv | 40 ++++
 rtl/mtimer_counter.sv | 53 +++++
 rtl/mtimer_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_mtimer_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// mtimer_pkg
// Shared definitions for the machine-timer responder: register byte offsets,
// ctrl bit positions, the bus FSM state type, the mtimecmp reset value and a
// byte-merge helper used by every byte-masked register write.
package mtimer_pkg;

    // Register byte offsets within the peripheral window
    localparam int MTIME_LO    = 'h00;
    localparam int MTIME_HI    = 'h04;
    localparam int MTIMECMP_LO = 'h08;
    localparam int MTIMECMP_HI = 'h0C;
    localparam int CTRL        = 'h10;

    // ctrl register bit positions
    localparam int CTRL_COUNT_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;

    // mtimecmp starts at the largest value so no interrupt fires before software programs it
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Replace the bytes of old_val selected by byte_en with the matching bytes of new_val
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  byte_en);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mtimer_counter.sv
// mtimer_counter
// Prescaler plus 64-bit free-running mtime with a byte-masked write port.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   count_en  advance the prescaler (and mtime on prescaler wrap)
//   wr_data   write data for either half of mtime
//   wr_lo_be  byte enables for a write to mtime[31:0]  (0 = no write)
//   wr_hi_be  byte enables for a write to mtime[63:32] (0 = no write)
//   mtime     current 64-bit time value
module mtimer_counter
    import mtimer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        count_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_lo_be,
    input  logic [3:0]  wr_hi_be,
    output logic [63:0] mtime
);

    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PCW-1:0] pre_cnt;
    logic           tick;

    assign tick = count_en && (pre_cnt == PCW'(PRESCALE - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (count_en) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    // A committed write wins over the increment for the whole 64-bit value:
    // written bytes take new data, everything else keeps its pre-increment value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime <= '0;
        end else if ((wr_lo_be != 4'b0) || (wr_hi_be != 4'b0)) begin
            mtime <= {merge_bytes(mtime[63:32], wr_data, wr_hi_be),
                      merge_bytes(mtime[31:0],  wr_data, wr_lo_be)};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/mtimer_responder.sv
// mtimer_responder
// Memory-mapped machine timer responder using the single_port_ram handshake.
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   address        byte address (bits [1:0] ignored)
//   write_data     write data
//   output_enable  read request
//   write_enable   write request (wins when both enables are high)
//   chip_select    peripheral selected
//   byte_enable    per-byte write mask
//   read_data      data of the most recent committed read
//   busy           access in progress
//   timer_irq      level machine-timer interrupt
// Optional feature: define MTIMER_SNAPSHOT_EN to make a read of mtime[31:0]
// capture mtime[63:32] into a shadow that later reads of mtime[63:32] return.
module mtimer_responder
    import mtimer_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int ADDR_SIZE   = 5,
    parameter int BUSY_CYCLES = 2,
    parameter int PRESCALE    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] address,
    input  logic [DATA_SIZE-1:0] write_data,
    input  logic                 output_enable,
    input  logic                 write_enable,
    input  logic                 chip_select,
    input  logic [3:0]           byte_enable,
    output logic [DATA_SIZE-1:0] read_data,
    output logic                 busy,
    output logic                 timer_irq
);

    localparam int WW  = ADDR_SIZE - 2;
    localparam int WCW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    localparam logic [WW-1:0] W_MTIME_LO    = WW'(MTIME_LO / 4);
    localparam logic [WW-1:0] W_MTIME_HI    = WW'(MTIME_HI / 4);
    localparam logic [WW-1:0] W_MTIMECMP_LO = WW'(MTIMECMP_LO / 4);
    localparam logic [WW-1:0] W_MTIMECMP_HI = WW'(MTIMECMP_HI / 4);
    localparam logic [WW-1:0] W_CTRL        = WW'(CTRL / 4);

    state_t         state, state_next;
    logic [WCW-1:0] wait_cnt, wait_cnt_next;
    logic           request, commit;

    logic           lat_write;
    logic [WW-1:0]  lat_word;
    logic [31:0]    lat_data;
    logic [3:0]     lat_be;

    logic           acc_write;
    logic [WW-1:0]  acc_word;
    logic [31:0]    acc_data;
    logic [3:0]     acc_be;
    logic           do_write;

    logic [63:0]    mtime, mtimecmp;
    logic [1:0]     ctrl;
    logic [31:0]    rd_value;
    logic [31:0]    mtime_hi_view;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];
    assign request          = chip_select & (output_enable | write_enable);
    assign busy             = (state == WAIT);

    // Bus FSM state and wait counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Capture the request at acceptance so later bus activity cannot disturb it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write <= 1'b0;
            lat_word  <= '0;
            lat_data  <= '0;
            lat_be    <= '0;
        end else if ((state == IDLE) && request) begin
            lat_write <= write_enable;
            lat_word  <= address[ADDR_SIZE-1:2];
            lat_data  <= write_data[31:0];
            lat_be    <= byte_enable;
        end
    end

    // Next-state logic; commit marks the edge where the access takes effect
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (BUSY_CYCLES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WCW'(BUSY_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero busy cycles the access commits at the request edge, so use live inputs
    always_comb begin
        if (BUSY_CYCLES == 0) begin
            acc_write = write_enable;
            acc_word  = address[ADDR_SIZE-1:2];
            acc_data  = write_data[31:0];
            acc_be    = byte_enable;
        end else begin
            acc_write = lat_write;
            acc_word  = lat_word;
            acc_data  = lat_data;
            acc_be    = lat_be;
        end
    end

    assign do_write = commit && acc_write;

    mtimer_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .count_en (ctrl[CTRL_COUNT_EN]),
        .wr_data  (acc_data),
        .wr_lo_be ((do_write && (acc_word == W_MTIME_LO)) ? acc_be : 4'b0),
        .wr_hi_be ((do_write && (acc_word == W_MTIME_HI)) ? acc_be : 4'b0),
        .mtime    (mtime)
    );

    // mtimecmp and ctrl registers; ctrl only has meaningful bits in byte 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtimecmp <= MTIMECMP_RESET;
            ctrl     <= '0;
        end else if (do_write) begin
            if (acc_word == W_MTIMECMP_LO) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], acc_data, acc_be);
            end
            if (acc_word == W_MTIMECMP_HI) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], acc_data, acc_be);
            end
            if ((acc_word == W_CTRL) && acc_be[0]) begin
                ctrl <= acc_data[1:0];
            end
        end
    end

    // Interrupt is registered from the current register values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= ctrl[CTRL_IRQ_EN] & (mtime >= mtimecmp);
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] mtime_hi_shadow;

    // Reading the low half freezes the high half for a coherent 64-bit read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_hi_shadow <= '0;
        end else if (commit && !acc_write && (acc_word == W_MTIME_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    assign mtime_hi_view = mtime_hi_shadow;
`else
    assign mtime_hi_view = mtime[63:32];
`endif

    // Read multiplexer; unmapped words read as zero
    always_comb begin
        rd_value = '0;
        case (acc_word)
            W_MTIME_LO:    rd_value = mtime[31:0];
            W_MTIME_HI:    rd_value = mtime_hi_view;
            W_MTIMECMP_LO: rd_value = mtimecmp[31:0];
            W_MTIMECMP_HI: rd_value = mtimecmp[63:32];
            W_CTRL:        rd_value = {30'b0, ctrl};
            default:       rd_value = '0;
        endcase
    end

    // read_data only changes when a read commits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
        end else if (commit && !acc_write) begin
            read_data <= DATA_SIZE'(rd_value);
        end
    end

endmodule

// File: tb/tb_mtimer_responder.sv
// tb_mtimer_responder
// Self-checking bench for mtimer_responder (BUSY_CYCLES=2, PRESCALE=4).
// A transaction-level model tracks mtime as a plain 64-bit count, a busy
// countdown and the register file; a compare process checks busy, timer_irq
// and read_data against it every cycle. Directed literal checks pin the model.
// Honours MTIMER_SNAPSHOT_EN in the same way as the design.
module tb_mtimer_responder;

    localparam int BC = 2;
    localparam int PS = 4;

    logic        clock         = 1'b0;
    logic        reset         = 1'b0;
    logic [4:0]  address       = '0;
    logic [31:0] write_data    = '0;
    logic        output_enable = 1'b0;
    logic        write_enable  = 1'b0;
    logic        chip_select   = 1'b0;
    logic [3:0]  byte_enable   = '0;
    logic [31:0] read_data;
    logic        busy;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    mtimer_responder #(
        .DATA_SIZE   (32),
        .ADDR_SIZE   (5),
        .BUSY_CYCLES (BC),
        .PRESCALE    (PS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .write_data    (write_data),
        .output_enable (output_enable),
        .write_enable  (write_enable),
        .chip_select   (chip_select),
        .byte_enable   (byte_enable),
        .read_data     (read_data),
        .busy          (busy),
        .timer_irq     (timer_irq)
    );

    initial forever #5 clock = ~clock;

    // Reference model state
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow, m_rdata;
    logic [1:0]  m_ctrl;
    logic        m_irq;
    int          m_pre, m_busy_left;
    logic        p_write;
    int          p_word;
    logic [31:0] p_data;
    logic [3:0]  p_be;

    function automatic logic [31:0] mergeModel(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Model: one update per clock edge, everything derived from pre-edge values
    initial begin
        logic [63:0] old_mtime, old_cmp, new_mtime;
        logic [1:0]  old_ctrl;
        logic        do_commit;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_ctrl = 0;
                m_pre = 0; m_busy_left = 0; m_rdata = 0; m_irq = 0; m_shadow = 0;
                p_write = 0; p_word = 0; p_data = 0; p_be = 0;
            end else begin
                old_mtime = m_mtime; old_cmp = m_cmp; old_ctrl = m_ctrl;
                m_irq = old_ctrl[1] && (old_mtime >= old_cmp);
                do_commit = 1'b0;
                if (m_busy_left > 0) begin
                    m_busy_left--;
                    if (m_busy_left == 0) do_commit = 1'b1;
                end else if (chip_select && (output_enable || write_enable)) begin
                    p_write = write_enable;
                    p_word  = int'(address[4:2]);
                    p_data  = write_data;
                    p_be    = byte_enable;
                    if (BC == 0) do_commit = 1'b1;
                    else m_busy_left = BC;
                end
                new_mtime = old_mtime;
                if (old_ctrl[0]) begin
                    if (m_pre == PS - 1) begin
                        m_pre = 0;
                        new_mtime = old_mtime + 64'd1;
                    end else begin
                        m_pre++;
                    end
                end
                if (do_commit && p_write) begin
                    case (p_word)
                        0: if (p_be != 0) new_mtime = {old_mtime[63:32], mergeModel(old_mtime[31:0], p_data, p_be)};
                        1: if (p_be != 0) new_mtime = {mergeModel(old_mtime[63:32], p_data, p_be), old_mtime[31:0]};
                        2: m_cmp[31:0]  = mergeModel(old_cmp[31:0], p_data, p_be);
                        3: m_cmp[63:32] = mergeModel(old_cmp[63:32], p_data, p_be);
                        4: if (p_be[0]) m_ctrl = p_data[1:0];
                        default: ;
                    endcase
                end else if (do_commit) begin
                    case (p_word)
                        0: begin
                            m_rdata  = old_mtime[31:0];
                            m_shadow = old_mtime[63:32];
                        end
`ifdef MTIMER_SNAPSHOT_EN
                        1: m_rdata = m_shadow;
`else
                        1: m_rdata = old_mtime[63:32];
`endif
                        2: m_rdata = old_cmp[31:0];
                        3: m_rdata = old_cmp[63:32];
                        4: m_rdata = {30'b0, old_ctrl};
                        default: m_rdata = 0;
                    endcase
                end
                m_mtime = new_mtime;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input logic [31:0] actual,
                              input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        if (actual < lo || actual > hi || $isunknown(actual)) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected range %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            checkOutput("busy", {63'b0, busy}, {63'b0, (m_busy_left > 0)});
            checkOutput("timer_irq", {63'b0, timer_irq}, {63'b0, m_irq});
            checkOutput("read_data", {32'b0, read_data}, {32'b0, m_rdata});
        end
    end

    // One complete bus access; junk is driven while busy to show it is ignored
    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                                 input logic [3:0] be, output logic [31:0] rdata,
                                 output int busy_cycles);
        chip_select   = 1'b1;
        write_enable  = wr;
        output_enable = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        address       = addr;
        write_data    = data;
        byte_enable   = be;
        @(posedge clock); #1;
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            chip_select   = 1'($urandom_range(0, 1));
            write_enable  = 1'($urandom_range(0, 1));
            output_enable = 1'($urandom_range(0, 1));
            address       = 5'($urandom);
            write_data    = $urandom;
            byte_enable   = 4'($urandom);
            @(posedge clock); #1;
            busy_cycles++;
        end
        chip_select   = 1'b0;
        write_enable  = 1'b0;
        output_enable = 1'b0;
        if (busy_cycles >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_timeout actual=busy stuck high expected=release within 20 cycles");
        end
        rdata = read_data;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] r;
        int n;
        applyStimulus(1'b1, addr, data, be, r, n);
    endtask

    task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
        int n;
        applyStimulus(1'b0, addr, 32'h0, 4'h0, data, n);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [31:0] r;
        int          n;

        // Reset and reset-state values
        #22 reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_read_data", {32'b0, read_data}, 64'd0);
        checkOutput("reset_irq", {63'b0, timer_irq}, 64'd0);
        readReg(5'h08, r);
        checkOutput("reset_mtimecmp_lo", {32'b0, r}, 64'hFFFF_FFFF);

        // Handshake length and ctrl readback
        applyStimulus(1'b1, 5'h10, 32'h0000_0003, 4'hF, r, n);
        checkOutput("busy_cycles", 64'(n), 64'd2);
        readReg(5'h10, r);
        checkOutput("ctrl_readback", {32'b0, r}, 64'd3);

        // Counting with prescale 4 over 40 idle cycles plus the read handshake
        writeReg(5'h10, 32'h0, 4'hF);
        writeReg(5'h00, 32'h0, 4'hF);
        writeReg(5'h04, 32'h0, 4'hF);
        writeReg(5'h10, 32'h1, 4'hF);
        waitCycles(40);
        readReg(5'h00, r);
        checkRange("count_prescaled", r, 32'd10, 32'd11);

        // Carry from the low into the high half
        writeReg(5'h10, 32'h0, 4'hF);
        writeReg(5'h00, 32'hFFFF_FFFF, 4'hF);
        writeReg(5'h04, 32'h0, 4'hF);
        writeReg(5'h10, 32'h1, 4'hF);
        waitCycles(8);
`ifndef MTIMER_SNAPSHOT_EN
        readReg(5'h04, r);
        checkOutput("wrap_hi", {32'b0, r}, 64'd1);
`endif
        readReg(5'h00, r);
        checkRange("wrap_lo", r, 32'd0, 32'd15);
        readReg(5'h04, r);
        checkOutput("wrap_hi_after_lo", {32'b0, r}, 64'd1);

        // Byte-masked write and unmapped window
        writeReg(5'h08, 32'hAABB_CCDD, 4'b0101);
        readReg(5'h08, r);
        checkOutput("byte_mask", {32'b0, r}, 64'hFFBB_FFDD);
        writeReg(5'h18, 32'h1234_5678, 4'hF);
        readReg(5'h18, r);
        checkOutput("unmapped_read", {32'b0, r}, 64'd0);

        // Interrupt assertion and one-cycle-lag deassertion
        writeReg(5'h10, 32'h0, 4'hF);
        writeReg(5'h08, 32'd20, 4'hF);
        writeReg(5'h0C, 32'd0, 4'hF);
        writeReg(5'h00, 32'd0, 4'hF);
        writeReg(5'h04, 32'd0, 4'hF);
        writeReg(5'h10, 32'h3, 4'hF);
        checkOutput("irq_before_match", {63'b0, timer_irq}, 64'd0);
        waitCycles(120);
        checkOutput("irq_asserted", {63'b0, timer_irq}, 64'd1);
        writeReg(5'h10, 32'h1, 4'hF);
        checkOutput("irq_lag", {63'b0, timer_irq}, 64'd1);
        waitCycles(1);
        checkOutput("irq_dropped", {63'b0, timer_irq}, 64'd0);

        // Coherent 64-bit read across a carry
        writeReg(5'h10, 32'h0, 4'hF);
        writeReg(5'h00, 32'hFFFF_FFFE, 4'hF);
        writeReg(5'h04, 32'h0, 4'hF);
        readReg(5'h00, r);
        checkOutput("snap_lo", {32'b0, r}, 64'hFFFF_FFFE);
        writeReg(5'h10, 32'h1, 4'hF);
        waitCycles(20);
        readReg(5'h04, r);
`ifdef MTIMER_SNAPSHOT_EN
        checkOutput("snap_hi_shadow", {32'b0, r}, 64'd0);
`else
        checkOutput("snap_hi_live", {32'b0, r}, 64'd1);
`endif

        // Random traffic checked by the model every cycle
        for (int t = 0; t < 300; t++) begin
            logic        wr;
            logic [31:0] d;
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            if ($urandom_range(0, 2) == 0) d = d & 32'h0000_00FF;
            applyStimulus(wr, 5'($urandom), d, 4'($urandom), r, n);
            if ($urandom_range(0, 3) == 0) waitCycles($urandom_range(1, 3));
        end

        // Reset asserted in the middle of a write: the write is lost
        readReg(5'h10, r);
        chip_select  = 1'b1;
        write_enable = 1'b1;
        address      = 5'h08;
        write_data   = 32'h0;
        byte_enable  = 4'hF;
        @(posedge clock); #1;
        chip_select  = 1'b0;
        write_enable = 1'b0;
        reset        = 1'b0;
        #1;
        checkOutput("midreset_busy", {63'b0, busy}, 64'd0);
        checkOutput("midreset_read_data", {32'b0, read_data}, 64'd0);
        checkOutput("midreset_irq", {63'b0, timer_irq}, 64'd0);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        readReg(5'h08, r);
        checkOutput("midreset_write_lost", {32'b0, r}, 64'hFFFF_FFFF);
        readReg(5'h10, r);
        checkOutput("midreset_ctrl", {32'b0, r}, 64'd0);

        waitCycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
